// File: rtl/mesi_snoop_bus_arbiter.sv
// mesi_snoop_bus_arbiter: round-robin owner of the shared MESI snoop bus.
// Grants one BusRd/BusRdX/BusUpgr at a time, broadcasts it to the snoopers,
// collects shared/flush responses, sequences the memory read, and returns
// completion plus the shared (C) indication to the owner.
// Ports: clk, rstb (async active-low); req_valid/req_cmd per cache;
//   grant/done one-hot to owner; c_out/err valid with done;
//   snoop_valid/snoop_cmd/snoop_src broadcast; snoop_shared/snoop_flush
//   responses; mem_req/mem_ack memory read handshake.
// Option: define MESI_ARB_TIMEOUT_EN to add a mem_ack watchdog that ends
//   the transaction with err=1 after TIMEOUT_CYCLES cycles in MEM.
module mesi_snoop_bus_arbiter #(
   parameter int NUM_CACHES     = 4,
   parameter int SNOOP_LAT      = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rstb,
   input  logic [NUM_CACHES-1:0]         req_valid,
   input  logic [2*NUM_CACHES-1:0]       req_cmd,
   output logic [NUM_CACHES-1:0]         grant,
   output logic [NUM_CACHES-1:0]         done,
   output logic                          c_out,
   output logic                          err,
   output logic                          snoop_valid,
   output logic [1:0]                    snoop_cmd,
   output logic [$clog2(NUM_CACHES)-1:0] snoop_src,
   input  logic [NUM_CACHES-1:0]         snoop_shared,
   input  logic [NUM_CACHES-1:0]         snoop_flush,
   output logic                          mem_req,
   input  logic                          mem_ack
);

   localparam int SW = $clog2(NUM_CACHES);
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_UPGR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_SNOOP, S_WAIT, S_MEM, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           owner_q, rr_q, win;
   logic [1:0]              cmd_q, win_cmd;
   logic [2:0]              lat_q;
   logic                    shared_q;
   logic                    err_q;
   logic [NUM_CACHES-1:0]   elig, owner_oh, shared_m, flush_m;
   logic                    found, last, need_mem;
   int                      idx;

   // Search starts one past the previous owner, so the last owner
   // always has lowest priority.
   always_comb begin
      elig    = '0;
      win     = rr_q;
      win_cmd = 2'b00;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_CACHES; i++)
         elig[i] = req_valid[i] & (req_cmd[2*i +: 2] != 2'b00);
      for (int k = 1; k <= NUM_CACHES; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CACHES) idx = idx - NUM_CACHES;
         if (!found && elig[idx]) begin
            found   = 1'b1;
            win     = SW'(idx);
            win_cmd = req_cmd[2*idx +: 2];
         end
      end
   end

   // The owner never snoops its own request.
   assign owner_oh = NUM_CACHES'(1) << owner_q;
   assign shared_m = snoop_shared & ~owner_oh;
   assign flush_m  = snoop_flush & ~owner_oh;
   assign last     = (lat_q == 3'(SNOOP_LAT - 1));
   assign need_mem = (cmd_q != CMD_UPGR) && !(|flush_m);

`ifdef MESI_ARB_TIMEOUT_EN
   logic [4:0] to_q;
   logic       to_hit;
`endif

   always_comb begin
      state_d = state_q;
`ifdef MESI_ARB_TIMEOUT_EN
      to_hit  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE:  if (found) state_d = S_GRANT;
         S_GRANT: state_d = S_SNOOP;
         S_SNOOP: state_d = S_WAIT;
         S_WAIT:  if (last) state_d = need_mem ? S_MEM : S_DONE;
         S_MEM: begin
            if (mem_ack) state_d = S_DONE;
`ifdef MESI_ARB_TIMEOUT_EN
            else if (to_q == 5'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               to_hit  = 1'b1;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         cmd_q    <= 2'b00;
         rr_q     <= SW'(NUM_CACHES - 1);
         lat_q    <= '0;
         shared_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && found) begin
            owner_q <= win;
            cmd_q   <= win_cmd;
         end
         lat_q <= (state_q == S_WAIT) ? lat_q + 3'd1 : 3'd0;
         if (state_q == S_WAIT && last) shared_q <= |shared_m;
         if (state_q == S_DONE) rr_q <= owner_q;
      end
   end

`ifdef MESI_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q <= (state_q == S_MEM) ? to_q + 5'd1 : 5'd0;
         if (state_q == S_MEM) err_q <= to_hit;
         else if (state_q == S_DONE) err_q <= 1'b0;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   // mem_req rises on the sampling cycle itself so a memory read starts
   // one cycle after the snoop strobe when SNOOP_LAT=1.
   assign grant       = (state_q != S_IDLE) ? owner_oh : '0;
   assign done        = (state_q == S_DONE) ? owner_oh : '0;
   assign err         = (state_q == S_DONE) & err_q;
   assign c_out       = (state_q == S_DONE) & (cmd_q == CMD_RD)
                        & shared_q & ~err_q;
   assign snoop_valid = (state_q == S_SNOOP);
   assign snoop_cmd   = snoop_valid ? cmd_q : 2'b00;
   assign snoop_src   = snoop_valid ? owner_q : '0;
   assign mem_req     = (state_q == S_MEM)
                        | ((state_q == S_WAIT) & last & need_mem);

endmodule
